// File: rtl/fp_cmd_queue_if.sv
// rtl/fp_cmd_queue_if.sv - CPU/execution-core signal bundle for fp_cmd_queue
interface fp_cmd_queue_if #(
  parameter int OP_W  = 32,
  parameter int SEL_W = 3,
  parameter int CNT_W = 4
);
  logic             op_strobe;
  logic [OP_W-1:0]  op1;
  logic [OP_W-1:0]  op2;
  logic [SEL_W-1:0] op_sel;
  logic             exec_start;
  logic [OP_W-1:0]  exec_op1;
  logic [OP_W-1:0]  exec_op2;
  logic [SEL_W-1:0] exec_op_sel;
  logic             exec_done;
  logic             result_full;
  logic             queue_full;
  logic             queue_empty;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             overflow;
  logic [15:0]      issue_cnt;

  modport master (
    output op_strobe, op1, op2, op_sel, exec_done, result_full,
    input  exec_start, exec_op1, exec_op2, exec_op_sel,
           queue_full, queue_empty, count, busy, overflow, issue_cnt
  );

  modport slave (
    input  op_strobe, op1, op2, op_sel, exec_done, result_full,
    output exec_start, exec_op1, exec_op2, exec_op_sel,
           queue_full, queue_empty, count, busy, overflow, issue_cnt
  );
endinterface

// File: rtl/fp_cmd_queue.sv
// rtl/fp_cmd_queue.sv - FP command FIFO and start/done issue controller
// Optional issue counter enabled by defining FP_CMD_ISSUE_CNT_EN.
module fp_cmd_queue #(
  parameter int DEPTH = 8,
  parameter int OP_W  = 32,
  parameter int SEL_W = 3
) (
  input logic           clk,
  input logic           n_rst,
  fp_cmd_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2 * OP_W + SEL_W;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t           state;
  logic             strobe_q;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             overflow_q;
  logic             exec_start_q;
  logic             busy_q;
  logic [OP_W-1:0]  exec_op1_q;
  logic [OP_W-1:0]  exec_op2_q;
  logic [SEL_W-1:0] exec_op_sel_q;
  logic [EW-1:0]    mem [DEPTH];

  logic push, pop, do_push, full, empty;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign push    = bus.op_strobe & ~strobe_q;
  assign pop     = (state == IDLE) && !empty && !bus.result_full;
  // A pop in the same cycle frees a slot, so a push while full still lands.
  assign do_push = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {bus.op1, bus.op2, bus.op_sel};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      strobe_q   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      overflow_q <= 1'b0;
    end else begin
      strobe_q <= bus.op_strobe;
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !pop) cnt <= cnt + CW'(1);
      else if (pop && !do_push) cnt <= cnt - CW'(1);
      if (push && !do_push) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      exec_start_q  <= 1'b0;
      busy_q        <= 1'b0;
      exec_op1_q    <= '0;
      exec_op2_q    <= '0;
      exec_op_sel_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            {exec_op1_q, exec_op2_q, exec_op_sel_q} <= mem[rd_ptr];
            exec_start_q <= 1'b1;
            busy_q       <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          exec_start_q <= 1'b0;
          if (bus.exec_done) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (bus.exec_done) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          exec_start_q <= 1'b0;
          busy_q       <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

`ifdef FP_CMD_ISSUE_CNT_EN
  logic [15:0] issue_cnt_q;

  // Counts at the same edge exec_start rises; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) issue_cnt_q <= '0;
    else if (pop) issue_cnt_q <= issue_cnt_q + 16'd1;
  end

  assign bus.issue_cnt = issue_cnt_q;
`else
  assign bus.issue_cnt = '0;
`endif

  assign bus.exec_start  = exec_start_q;
  assign bus.exec_op1    = exec_op1_q;
  assign bus.exec_op2    = exec_op2_q;
  assign bus.exec_op_sel = exec_op_sel_q;
  assign bus.queue_full  = full;
  assign bus.queue_empty = empty;
  assign bus.count       = cnt;
  assign bus.busy        = busy_q;
  assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_fp_cmd_queue.sv
// tb/tb_fp_cmd_queue.sv - directed self-checking bench for fp_cmd_queue
module tb_fp_cmd_queue;
  localparam int DEPTH = 8;
  localparam int OP_W  = 32;
  localparam int SEL_W = 3;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   vecs = 0;
  int   errs = 0;
  int   cyc = 0;
  int   start_cnt = 0;

  fp_cmd_queue_if #(.OP_W(OP_W), .SEL_W(SEL_W), .CNT_W(CW)) bus ();

  fp_cmd_queue #(.DEPTH(DEPTH), .OP_W(OP_W), .SEL_W(SEL_W)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.exec_start === 1'b1) start_cnt <= start_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    n_rst = 1'b0;
    bus.op_strobe = 1'b0;
    bus.exec_done = 1'b0;
    bus.result_full = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    tick();
  endtask

  task automatic push_cmd(input logic [31:0] a, input logic [31:0] b, input logic [2:0] s);
    bus.op1 = a;
    bus.op2 = b;
    bus.op_sel = s;
    bus.op_strobe = 1'b1;
    tick();
    bus.op_strobe = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    bus.op_strobe = 1'b0;
    bus.op1 = '0;
    bus.op2 = '0;
    bus.op_sel = '0;
    bus.exec_done = 1'b0;
    bus.result_full = 1'b0;
    tick();
    vecs++;
    if ({bus.exec_start, bus.busy, bus.overflow, bus.queue_full, bus.queue_empty} !== 5'b00001) begin
      errs++;
      $display("FAIL reset_flags: got %b expected 00001",
               {bus.exec_start, bus.busy, bus.overflow, bus.queue_full, bus.queue_empty});
    end
    vecs++;
    if (bus.count !== '0 || bus.issue_cnt !== 16'd0 || bus.exec_op1 !== '0 || bus.exec_op_sel !== '0) begin
      errs++;
      $display("FAIL reset_values: count=%0d issue_cnt=%0d op1=%h sel=%b expected all 0",
               bus.count, bus.issue_cnt, bus.exec_op1, bus.exec_op_sel);
    end
    n_rst = 1'b1;
    tick();
  endtask

  task automatic test_single_push();
    apply_reset();
    bus.op1 = 32'hC475_C000;
    bus.op2 = 32'h4A1F_E982;
    bus.op_sel = 3'b001;
    bus.op_strobe = 1'b1;
    tick();
    vecs++;
    if (bus.count !== 4'd1 || bus.exec_start !== 1'b0) begin
      errs++;
      $display("FAIL push_edge: count=%0d start=%b expected count=1 start=0", bus.count, bus.exec_start);
    end
    bus.op_strobe = 1'b0;
    tick();
    vecs++;
    if (bus.exec_start !== 1'b1 || bus.busy !== 1'b1 || bus.count !== 4'd0) begin
      errs++;
      $display("FAIL issue_edge: start=%b busy=%b count=%0d expected 1 1 0",
               bus.exec_start, bus.busy, bus.count);
    end
    vecs++;
    if (bus.exec_op1 !== 32'hC475_C000 || bus.exec_op2 !== 32'h4A1F_E982 || bus.exec_op_sel !== 3'b001) begin
      errs++;
      $display("FAIL issue_data: got %h %h %b expected c475c000 4a1fe982 001",
               bus.exec_op1, bus.exec_op2, bus.exec_op_sel);
    end
    tick();
    tick();
    vecs++;
    if (bus.exec_start !== 1'b0 || bus.busy !== 1'b1 || bus.exec_op1 !== 32'hC475_C000) begin
      errs++;
      $display("FAIL start_pulse: start=%b busy=%b op1=%h expected 0 1 c475c000",
               bus.exec_start, bus.busy, bus.exec_op1);
    end
    bus.exec_done = 1'b1;
    tick();
    bus.exec_done = 1'b0;
    vecs++;
    if (bus.busy !== 1'b0) begin
      errs++;
      $display("FAIL done_idle: busy=%b expected 0", bus.busy);
    end
  endtask

  task automatic test_hold_strobe();
    apply_reset();
    bus.result_full = 1'b1;
    bus.op1 = 32'h1111_2222;
    bus.op_strobe = 1'b1;
    repeat (5) tick();
    bus.op_strobe = 1'b0;
    vecs++;
    if (bus.count !== 4'd1 || bus.exec_start !== 1'b0) begin
      errs++;
      $display("FAIL hold_one_push: count=%0d start=%b expected 1 0", bus.count, bus.exec_start);
    end
    bus.result_full = 1'b0;
    tick();
    vecs++;
    if (bus.exec_start !== 1'b1 || bus.exec_op1 !== 32'h1111_2222) begin
      errs++;
      $display("FAIL hold_issue: start=%b op1=%h expected 1 11112222", bus.exec_start, bus.exec_op1);
    end
  endtask

  task automatic test_overflow();
    int base;
    apply_reset();
    base = start_cnt;
    for (int i = 0; i < DEPTH + 1; i++) push_cmd(32'hA000_0000 + i, 32'h0, 3'd0);
    vecs++;
    if (bus.queue_full !== 1'b1 || bus.overflow !== 1'b0 || bus.count !== 4'd8) begin
      errs++;
      $display("FAIL fill: full=%b ovf=%b count=%0d expected 1 0 8", bus.queue_full, bus.overflow, bus.count);
    end
    push_cmd(32'hDEAD_0000, 32'h0, 3'd0);
    repeat (3) tick();
    vecs++;
    if (bus.overflow !== 1'b1 || bus.count !== 4'd8) begin
      errs++;
      $display("FAIL overflow: ovf=%b count=%0d expected 1 8", bus.overflow, bus.count);
    end
    vecs++;
    if (start_cnt - base !== 1 || bus.exec_op1 !== 32'hA000_0000 || bus.busy !== 1'b1) begin
      errs++;
      $display("FAIL ovf_issue: starts=%0d op1=%h busy=%b expected 1 a0000000 1",
               start_cnt - base, bus.exec_op1, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    int t_prev;
    int n;
    apply_reset();
    t_prev = 0;
    bus.result_full = 1'b1;
    for (int i = 0; i < 6; i++) push_cmd(32'h3F80_0000 + i, 32'h4000_0000 + i, 3'(i));
    bus.result_full = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n = 0;
      while (bus.exec_start !== 1'b1 && n < 10) begin
        tick();
        n++;
      end
      vecs++;
      if (n >= 10) begin
        errs++;
        $display("FAIL b2b_timeout: op %0d never started", i);
      end
      vecs++;
      if (bus.exec_op1 !== 32'h3F80_0000 + i || bus.exec_op_sel !== 3'(i)) begin
        errs++;
        $display("FAIL b2b_order: op %0d got %h/%b expected %h/%b",
                 i, bus.exec_op1, bus.exec_op_sel, 32'h3F80_0000 + i, 3'(i));
      end
      if (i > 0) begin
        vecs++;
        if (cyc - t_prev !== 4) begin
          errs++;
          $display("FAIL b2b_spacing: op %0d spacing %0d expected 4", i, cyc - t_prev);
        end
      end
      t_prev = cyc;
      tick();
      tick();
      bus.exec_done = 1'b1;
      tick();
      bus.exec_done = 1'b0;
    end
    vecs++;
    if (bus.queue_empty !== 1'b1 || bus.busy !== 1'b0) begin
      errs++;
      $display("FAIL b2b_drain: empty=%b busy=%b expected 1 0", bus.queue_empty, bus.busy);
    end
    vecs++;
`ifdef FP_CMD_ISSUE_CNT_EN
    if (bus.issue_cnt !== 16'd6) begin
      errs++;
      $display("FAIL issue_cnt: got %0d expected 6", bus.issue_cnt);
    end
`else
    if (bus.issue_cnt !== 16'd0) begin
      errs++;
      $display("FAIL issue_cnt: got %0d expected 0", bus.issue_cnt);
    end
`endif
  endtask

  task automatic test_result_full();
    int base;
    apply_reset();
    base = start_cnt;
    bus.result_full = 1'b1;
    push_cmd(32'h0000_0101, 32'h0, 3'd1);
    push_cmd(32'h0000_0202, 32'h0, 3'd2);
    repeat (3) tick();
    vecs++;
    if (start_cnt - base !== 0 || bus.count !== 4'd2 || bus.busy !== 1'b0) begin
      errs++;
      $display("FAIL rf_block: starts=%0d count=%0d busy=%b expected 0 2 0",
               start_cnt - base, bus.count, bus.busy);
    end
    bus.result_full = 1'b0;
    tick();
    vecs++;
    if (bus.exec_start !== 1'b1 || bus.exec_op1 !== 32'h0000_0101 || bus.count !== 4'd1) begin
      errs++;
      $display("FAIL rf_release: start=%b op1=%h count=%0d expected 1 00000101 1",
               bus.exec_start, bus.exec_op1, bus.count);
    end
    bus.result_full = 1'b1;
    tick();
    bus.exec_done = 1'b1;
    tick();
    bus.exec_done = 1'b0;
    tick();
    tick();
    vecs++;
    if (bus.busy !== 1'b0 || bus.count !== 4'd1 || start_cnt - base !== 1) begin
      errs++;
      $display("FAIL rf_inflight: busy=%b count=%0d starts=%0d expected 0 1 1",
               bus.busy, bus.count, start_cnt - base);
    end
    bus.result_full = 1'b0;
    tick();
    vecs++;
    if (bus.exec_start !== 1'b1 || bus.exec_op1 !== 32'h0000_0202) begin
      errs++;
      $display("FAIL rf_second: start=%b op1=%h expected 1 00000202", bus.exec_start, bus.exec_op1);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    apply_reset();
    for (int i = 0; i < 4; i++) push_cmd(32'h5555_0000 + i, 32'h1, 3'd5);
    vecs++;
    if (bus.count !== 4'd3 || bus.busy !== 1'b1) begin
      errs++;
      $display("FAIL pre_reset: count=%0d busy=%b expected 3 1", bus.count, bus.busy);
    end
    #3;
    n_rst = 1'b0;
    #1;
    vecs++;
    if ({bus.exec_start, bus.busy, bus.overflow, bus.queue_full, bus.queue_empty} !== 5'b00001
        || bus.count !== '0 || bus.exec_op1 !== '0 || bus.exec_op_sel !== '0) begin
      errs++;
      $display("FAIL async_reset: flags=%b count=%0d op1=%h sel=%b expected 00001 0 0 0",
               {bus.exec_start, bus.busy, bus.overflow, bus.queue_full, bus.queue_empty},
               bus.count, bus.exec_op1, bus.exec_op_sel);
    end
    repeat (2) @(posedge clk);
    #2;
    n_rst = 1'b1;
    base = start_cnt;
    repeat (5) tick();
    vecs++;
    if (start_cnt - base !== 0 || bus.count !== '0 || bus.busy !== 1'b0) begin
      errs++;
      $display("FAIL post_reset: starts=%0d count=%0d busy=%b expected 0 0 0",
               start_cnt - base, bus.count, bus.busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_hold_strobe();
    test_overflow();
    test_back_to_back();
    test_result_full();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
